captura_operandos: RTL and testbench
====================================

# captura_operandos

Keypad entry controller that sits directly upstream of the three-digit BCD adder. It takes decoded key codes from the keypad scanner and assembles two 3-digit BCD operands, one digit per key press. It presents the operands on ports shaped for the adder's digit inputs and signals when both are complete. A display stage uses its mode output to select operand 1, operand 2 or the result.

## Interface
- TIMEOUT_CYCLES, default 27_000_000: idle cycles before an incomplete entry is abandoned; used only with the timeout feature.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- key_valid  in  1  high for as long as a key is held; synchronous to clk.
- key_code  in  4  stable while key_valid is high. 0x0–0x9 digit, 0xA confirm, 0xC clear, others ignored.
- dig1_1, dig1_2, dig1_3  out  4 each  operand 1 units, tens, hundreds (BCD).
- dig2_1, dig2_2, dig2_3  out  4 each  operand 2 units, tens, hundreds (BCD).
- modo  out  2  0 = entering op1, 1 = entering op2, 2 = result shown.
- cuenta  out  2  digits entered into the current operand, 0–3.
- listo  out  1  one-cycle pulse when op2 is confirmed.

## Operation
- Key event: a cycle where key_valid = 1 and the registered previous key_valid = 0. A held key produces exactly one event.
- FSM states:
  - S_OP1 (modo 0): entering operand 1.
  - S_OP2 (modo 1): entering operand 2.
  - S_RES (modo 2): result shown.
- Digit in S_OP1 or S_OP2 with cuenta < 3:
  - the current operand shifts left one digit: hundreds ← tens, tens ← units, units ← key_code;
  - cuenta increments.
- Digit with cuenta = 3: ignored, no change.
- Confirm:
  - in S_OP1 → S_OP2, cuenta ← 0;
  - in S_OP2 → S_RES, listo pulses, cuenta ← 0;
  - in S_RES: ignored.
- Confirm with cuenta = 0 is legal; that operand is 000.
- Digit in S_RES: all six digits cleared, then the digit loads into dig1_1. Next state S_OP1, cuenta = 1.
- Clear in any state: all digits 0, cuenta 0, state S_OP1.
- Ignored codes (0xB, 0xD–0xF) produce no change and do not restart the timeout counter.
- Operands are held stable in S_RES, so the adder output is valid for the entire state.

## Timing
- Reset values:
  - all dig* = 0, modo = 0, cuenta = 0, listo = 0;
  - state S_OP1, previous key_valid = 0, timeout counter = 0.
- Latency: outputs reflect a key event on the rising edge that ends the cycle in which the event is detected. That is one clk after key_valid is first sampled high.
- listo is high for exactly the cycle after that edge. It is never high for two consecutive cycles.
- Reset asserted mid-entry clears everything immediately, without waiting for clk.
- key_valid already high when reset deasserts: the previous-value register starts at 0, so this counts as one event on the first clk.
- Back-to-back events are not possible; each needs a low cycle in between.

## Configuration
- ENTRY_TIMEOUT_EN defined:
  - a counter runs in S_OP1 and S_OP2 and restarts to 0 on every accepted key event;
  - on reaching TIMEOUT_CYCLES − 1 it performs the clear action on the next edge;
  - in S_RES the counter is held at 0.
- ENTRY_TIMEOUT_EN undefined: no counter is built, TIMEOUT_CYCLES is unused, and entry waits indefinitely.

## Structure
- Shared package captura_pkg holds:
  - key code constants: KEY_CONFIRM = 4'hA, KEY_CLEAR = 4'hC;
  - the state enum with S_OP1/S_OP2/S_RES encoded as 0/1/2, so modo equals the state;
  - a 3-digit BCD operand typedef.
- One sub-module, detector_flanco: registers key_valid and outputs the one-cycle event pulse.

## Test plan
- Reset, then keys 1,2,3, confirm, 4,5,6, confirm → dig1 = 1/2/3 hundreds-to-units, i.e. dig1_3 = 1, dig1_2 = 2, dig1_1 = 3. dig2 = 4,5,6 likewise; listo pulses once; modo = 2.
- Keys 7,8,9,5 in S_OP1 → fourth digit ignored, operand 789, cuenta = 3.
- key_valid held high for 50 cycles with code 0x4 → single digit entered, cuenta = 1.
- Operand 2 entered as 12, then clear → all digits 0, modo = 0, cuenta = 0, listo never asserted.
- In S_RES, press 9 → op2 = 000, op1 = 009, modo = 0, cuenta = 1. Assert rst_n low mid-entry → outputs 0 asynchronously.
- With ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES = 16: enter 5, idle 16 cycles → cleared to S_OP1. In S_RES, idle 100 cycles → no change.

Source files
------------

// File: rtl/captura_pkg.sv
// Shared types and constants for the keypad operand-entry controller.
package captura_pkg;

  localparam int unsigned DIG_W  = 4;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned MODO_W = 2;

  localparam logic [DIG_W-1:0] KEY_CONFIRM = 4'hA;
  localparam logic [DIG_W-1:0] KEY_CLEAR   = 4'hC;
  localparam logic [DIG_W-1:0] MAX_DIGITO  = 4'h9;
  localparam logic [CNT_W-1:0] MAX_CUENTA  = 2'd3;

  // Encoding matches the modo output so the state register drives it directly.
  typedef enum logic [MODO_W-1:0] {
    S_OP1 = 2'd0,
    S_OP2 = 2'd1,
    S_RES = 2'd2
  } estado_t;

  typedef struct packed {
    logic [DIG_W-1:0] centenas;
    logic [DIG_W-1:0] decenas;
    logic [DIG_W-1:0] unidades;
  } operando_t;

  function automatic logic es_digito(logic [DIG_W-1:0] code);
    return code <= MAX_DIGITO;
  endfunction

  function automatic operando_t desplazar(operando_t op, logic [DIG_W-1:0] d);
    operando_t r;
    r.centenas = op.decenas;
    r.decenas  = op.unidades;
    r.unidades = d;
    return r;
  endfunction

endpackage

// File: rtl/captura_operandos_if.sv
// Keypad-side and adder/display-side signals of captura_operandos.
interface captura_operandos_if;
  import captura_pkg::*;

  logic                key_valid;
  logic [DIG_W-1:0]    key_code;
  logic [DIG_W-1:0]    dig1_1;
  logic [DIG_W-1:0]    dig1_2;
  logic [DIG_W-1:0]    dig1_3;
  logic [DIG_W-1:0]    dig2_1;
  logic [DIG_W-1:0]    dig2_2;
  logic [DIG_W-1:0]    dig2_3;
  logic [MODO_W-1:0]   modo;
  logic [CNT_W-1:0]    cuenta;
  logic                listo;

  modport slave (
    input  key_valid, key_code,
    output dig1_1, dig1_2, dig1_3, dig2_1, dig2_2, dig2_3, modo, cuenta, listo
  );

  modport master (
    output key_valid, key_code,
    input  dig1_1, dig1_2, dig1_3, dig2_1, dig2_2, dig2_3, modo, cuenta, listo
  );

endinterface

// File: rtl/captura_operandos_detector_flanco.sv
// Rising-edge detector for key_valid: one-cycle pulse per key press.
module detector_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic key_valid_i,
  output logic evento_c_o
);

  logic key_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_valid_q <= 1'b0;
    else        key_valid_q <= key_valid_i;
  end

  assign evento_c_o = key_valid_i & ~key_valid_q;

endmodule

// File: rtl/captura_operandos.sv
// Assembles two 3-digit BCD operands from keypad codes for the BCD adder.
// Optional entry timeout built when ENTRY_TIMEOUT_EN is defined.
module captura_operandos
  import captura_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  captura_operandos_if.slave  bus_io
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_invalido
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  estado_t          state_q, state_d;
  operando_t        op1_q, op1_d;
  operando_t        op2_q, op2_d;
  logic [CNT_W-1:0] cuenta_q, cuenta_d;
  logic             listo_q, listo_d;
  logic             evento_c;
  logic             acepta_c;
  logic             timeout_c;
  logic [DIG_W-1:0] code;

  detector_flanco u_detector (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid_i (bus_io.key_valid),
    .evento_c_o  (evento_c)
  );

  assign code     = bus_io.key_code;
  assign acepta_c = evento_c & (es_digito(code) | (code == KEY_CONFIRM) | (code == KEY_CLEAR));

`ifdef ENTRY_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign timeout_c = (state_q != S_RES) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Idle counter: restarts on accepted keys, parked at zero while the result is shown.
  always_comb begin
    to_cnt_d = to_cnt_q + TO_W'(1);
    if (state_q == S_RES || acepta_c || timeout_c) begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OP1;
      op1_q    <= '0;
      op2_q    <= '0;
      cuenta_q <= '0;
      listo_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      cuenta_q <= cuenta_d;
      listo_q  <= listo_d;
    end
  end

  // Key handling; a timeout acts exactly like the clear key.
  always_comb begin
    state_d  = state_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    cuenta_d = cuenta_q;
    listo_d  = 1'b0;

    if (acepta_c) begin
      if (es_digito(code)) begin
        if (state_q == S_RES) begin
          op1_d          = '0;
          op1_d.unidades = code;
          op2_d          = '0;
          cuenta_d       = CNT_W'(1);
          state_d        = S_OP1;
        end else if (cuenta_q < MAX_CUENTA) begin
          cuenta_d = cuenta_q + CNT_W'(1);
          if (state_q == S_OP1) op1_d = desplazar(op1_q, code);
          else                  op2_d = desplazar(op2_q, code);
        end
      end else if (code == KEY_CONFIRM) begin
        case (state_q)
          S_OP1: begin
            state_d  = S_OP2;
            cuenta_d = '0;
          end
          S_OP2: begin
            state_d  = S_RES;
            cuenta_d = '0;
            listo_d  = 1'b1;
          end
          default: ;
        endcase
      end else begin
        state_d  = S_OP1;
        op1_d    = '0;
        op2_d    = '0;
        cuenta_d = '0;
      end
    end else if (timeout_c) begin
      state_d  = S_OP1;
      op1_d    = '0;
      op2_d    = '0;
      cuenta_d = '0;
    end
  end

  assign bus_io.dig1_1 = op1_q.unidades;
  assign bus_io.dig1_2 = op1_q.decenas;
  assign bus_io.dig1_3 = op1_q.centenas;
  assign bus_io.dig2_1 = op2_q.unidades;
  assign bus_io.dig2_2 = op2_q.decenas;
  assign bus_io.dig2_3 = op2_q.centenas;
  assign bus_io.modo   = MODO_W'(state_q);
  assign bus_io.cuenta = cuenta_q;
  assign bus_io.listo  = listo_q;

endmodule

// File: tb/tb_captura_operandos.sv
// Scoreboard bench for captura_operandos: a behavioural keypad model predicts every output.
module tb_captura_operandos;

  logic clk;
  logic rst_n;

  captura_operandos_if bus();

  captura_operandos #(.TIMEOUT_CYCLES(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Output snapshot: op1 hundreds..units, op2 hundreds..units, modo, cuenta, listo.
  logic [28:0] sb[$];
  logic [28:0] exp_v, act_v;

  logic [3:0] m1 [3];
  logic [3:0] m2 [3];
  logic [1:0] m_modo;
  logic [1:0] m_cnt;
  int         m_listos = 0;

  int   listo_cnt = 0;
  logic listo_prev = 1'b0;
  logic listo_doble = 1'b0;

  always @(negedge clk) begin
    if (bus.listo === 1'b1) begin
      listo_cnt = listo_cnt + 1;
      if (listo_prev === 1'b1) listo_doble = 1'b1;
    end
    listo_prev = bus.listo;
  end

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m1[i] = 4'h0;
      m2[i] = 4'h0;
    end
    m_modo = 2'd0;
    m_cnt  = 2'd0;
  endtask

  task automatic model_key(input logic [3:0] c, output logic l);
    l = 1'b0;
    if (c <= 4'h9) begin
      if (m_modo == 2'd2) begin
        model_clear();
        m1[0] = c;
        m_cnt = 2'd1;
      end else if (m_cnt != 2'd3) begin
        if (m_modo == 2'd0) begin
          m1[2] = m1[1]; m1[1] = m1[0]; m1[0] = c;
        end else begin
          m2[2] = m2[1]; m2[1] = m2[0]; m2[0] = c;
        end
        m_cnt = m_cnt + 2'd1;
      end
    end else if (c == 4'hA) begin
      if (m_modo == 2'd0) begin
        m_modo = 2'd1; m_cnt = 2'd0;
      end else if (m_modo == 2'd1) begin
        m_modo = 2'd2; m_cnt = 2'd0; l = 1'b1;
        m_listos = m_listos + 1;
      end
    end else if (c == 4'hC) begin
      model_clear();
    end
  endtask

  function automatic logic [28:0] model_vec(input logic l);
    return {m1[2], m1[1], m1[0], m2[2], m2[1], m2[0], m_modo, m_cnt, l};
  endfunction

  function automatic logic [28:0] snap();
    return {bus.dig1_3, bus.dig1_2, bus.dig1_1, bus.dig2_3, bus.dig2_2, bus.dig2_1,
            bus.modo, bus.cuenta, bus.listo};
  endfunction

  // Raises key_valid, predicts the outcome, and returns at the negedge after the event edge.
  task automatic press_start(input logic [3:0] c);
    logic l;
    @(posedge clk); #1;
    bus.key_code  = c;
    bus.key_valid = 1'b1;
    model_key(c, l);
    sb.push_back(model_vec(l));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_key(input int hold);
    repeat (hold - 1) @(negedge clk);
    bus.key_valid = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    model_clear();
    repeat (3) @(negedge clk);
    n_vec++;
    if (snap() !== 29'h0) begin
      n_err++; $display("FAIL reset got %h want %h", snap(), 29'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (snap() !== 29'h0) begin
      n_err++; $display("FAIL reset_release got %h want %h", snap(), 29'h0);
    end
  endtask

  task automatic test_basic();
    logic [3:0] codes [8] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hA};
    for (int i = 0; i < 8; i++) begin
      press_start(codes[i]);
      exp_v = sb.pop_front(); act_v = snap(); n_vec++;
      if (act_v !== exp_v) begin
        n_err++; $display("FAIL basic[%0d] got %h want %h", i, act_v, exp_v);
      end
      release_key(1);
    end
    @(negedge clk);
    n_vec++;
    if ({bus.dig1_3, bus.dig1_2, bus.dig1_1} !== 12'h123) begin
      n_err++; $display("FAIL basic_op1 got %h want 123", {bus.dig1_3, bus.dig1_2, bus.dig1_1});
    end
    n_vec++;
    if ({bus.dig2_3, bus.dig2_2, bus.dig2_1, bus.modo, bus.listo} !== {12'h456, 2'd2, 1'b0}) begin
      n_err++; $display("FAIL basic_op2_modo got %h want %h",
                        {bus.dig2_3, bus.dig2_2, bus.dig2_1, bus.modo, bus.listo}, {12'h456, 2'd2, 1'b0});
    end
  endtask

  task automatic test_res_idle();
    repeat (100) @(posedge clk);
    @(negedge clk);
    exp_v = model_vec(1'b0); act_v = snap(); n_vec++;
    if (act_v !== exp_v) begin
      n_err++; $display("FAIL res_idle got %h want %h", act_v, exp_v);
    end
  endtask

  task automatic test_res_digit();
    press_start(4'h9);
    exp_v = sb.pop_front(); act_v = snap(); n_vec++;
    if (act_v !== exp_v) begin
      n_err++; $display("FAIL res_digit got %h want %h", act_v, exp_v);
    end
    n_vec++;
    if (act_v !== {12'h009, 12'h000, 2'd0, 2'd1, 1'b0}) begin
      n_err++; $display("FAIL res_digit_const got %h want %h", act_v, {12'h009, 12'h000, 2'd0, 2'd1, 1'b0});
    end
    release_key(1);
  endtask

  task automatic test_overflow();
    logic [3:0] codes [5] = '{4'hC, 4'h7, 4'h8, 4'h9, 4'h5};
    for (int i = 0; i < 5; i++) begin
      press_start(codes[i]);
      exp_v = sb.pop_front(); act_v = snap(); n_vec++;
      if (act_v !== exp_v) begin
        n_err++; $display("FAIL overflow[%0d] got %h want %h", i, act_v, exp_v);
      end
      release_key(1);
    end
    n_vec++;
    if ({bus.dig1_3, bus.dig1_2, bus.dig1_1, bus.cuenta} !== {12'h789, 2'd3}) begin
      n_err++; $display("FAIL overflow_const got %h want %h",
                        {bus.dig1_3, bus.dig1_2, bus.dig1_1, bus.cuenta}, {12'h789, 2'd3});
    end
  endtask

  task automatic test_hold();
    press_start(4'hC);
    exp_v = sb.pop_front(); act_v = snap(); n_vec++;
    if (act_v !== exp_v) begin
      n_err++; $display("FAIL hold_clear got %h want %h", act_v, exp_v);
    end
    release_key(1);
    press_start(4'h4);
    exp_v = sb.pop_front();
    release_key(50);
    @(negedge clk);
    act_v = snap(); n_vec++;
    if (act_v !== exp_v || bus.cuenta !== 2'd1) begin
      n_err++; $display("FAIL hold got %h want %h", act_v, exp_v);
    end
  endtask

  task automatic test_clear_and_ignored();
    logic [3:0] codes [9] = '{4'hA, 4'h1, 4'hB, 4'h2, 4'hD, 4'hE, 4'hF, 4'hC, 4'hA};
    int listo_base;
    listo_base = listo_cnt;
    for (int i = 0; i < 8; i++) begin
      press_start(codes[i]);
      exp_v = sb.pop_front(); act_v = snap(); n_vec++;
      if (act_v !== exp_v) begin
        n_err++; $display("FAIL clear_ign[%0d] got %h want %h", i, act_v, exp_v);
      end
      release_key(1);
    end
    n_vec++;
    if (listo_cnt !== listo_base || snap() !== 29'h0) begin
      n_err++; $display("FAIL clear_state got %h listo %0d want 0 listo %0d", snap(), listo_cnt, listo_base);
    end
  endtask

  task automatic test_empty_confirm();
    for (int i = 0; i < 2; i++) begin
      press_start(4'hA);
      exp_v = sb.pop_front(); act_v = snap(); n_vec++;
      if (act_v !== exp_v) begin
        n_err++; $display("FAIL empty_confirm[%0d] got %h want %h", i, act_v, exp_v);
      end
      release_key(1);
    end
  endtask

  task automatic test_timeout();
    press_start(4'hC);
    exp_v = sb.pop_front(); act_v = snap(); n_vec++;
    if (act_v !== exp_v) begin
      n_err++; $display("FAIL to_clear got %h want %h", act_v, exp_v);
    end
    release_key(1);
    press_start(4'h5);
    exp_v = sb.pop_front(); act_v = snap(); n_vec++;
    if (act_v !== exp_v) begin
      n_err++; $display("FAIL to_digit got %h want %h", act_v, exp_v);
    end
    release_key(1);
    repeat (14) @(posedge clk);
    @(negedge clk);
    exp_v = model_vec(1'b0); act_v = snap(); n_vec++;
    if (act_v !== exp_v) begin
      n_err++; $display("FAIL to_before got %h want %h", act_v, exp_v);
    end
`ifdef ENTRY_TIMEOUT_EN
    model_clear();
`endif
    repeat (90) @(posedge clk);
    @(negedge clk);
    exp_v = model_vec(1'b0); act_v = snap(); n_vec++;
    if (act_v !== exp_v) begin
      n_err++; $display("FAIL to_after got %h want %h", act_v, exp_v);
    end
  endtask

  task automatic test_async_reset();
    press_start(4'h3);
    exp_v = sb.pop_front(); act_v = snap(); n_vec++;
    if (act_v !== exp_v) begin
      n_err++; $display("FAIL async_pre got %h want %h", act_v, exp_v);
    end
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    n_vec++;
    if (snap() !== 29'h0) begin
      n_err++; $display("FAIL async_reset got %h want %h", snap(), 29'h0);
    end
    bus.key_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_key_at_reset();
    logic l;
    rst_n = 1'b0;
    bus.key_code  = 4'h7;
    bus.key_valid = 1'b1;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    model_key(4'h7, l);
    sb.push_back(model_vec(l));
    @(posedge clk);
    @(negedge clk);
    exp_v = sb.pop_front(); act_v = snap(); n_vec++;
    if (act_v !== exp_v) begin
      n_err++; $display("FAIL key_at_reset got %h want %h", act_v, exp_v);
    end
    release_key(5);
  endtask

  task automatic test_listo_pulses();
    n_vec++;
    if (listo_cnt !== m_listos || listo_doble !== 1'b0) begin
      n_err++; $display("FAIL listo_pulses got %0d double %0b want %0d double 0",
                        listo_cnt, listo_doble, m_listos);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_res_idle();
    test_res_digit();
    test_overflow();
    test_hold();
    test_clear_and_ignored();
    test_empty_confirm();
    test_res_idle();
    test_timeout();
    test_async_reset();
    test_key_at_reset();
    test_listo_pulses();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
